adaptive_stream_checker: RTL

ADAPTIVE_STREAM_CHECKER -- requirements
Module: adaptive_stream_checker

---
 rtl/adaptive_stream_checker.sv | 106 ++++++++++
 1 files changed

// File: rtl/adaptive_stream_checker.sv
// Compares a filter output stream against a preloaded golden table, one run per start pulse.
// Reports mismatch count, first failing index, and a watchdog timeout when the stream stalls.
module adaptive_stream_checker #(
    parameter int WORDLENGTH = 14,
    parameter int DATA_NUM   = 128,
    parameter int TIMEOUT    = 1024,
    localparam int AW        = $clog2(DATA_NUM),
    localparam int WW        = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    input  logic                  ref_wr_en,
    input  logic [AW-1:0]         ref_wr_addr,
    input  logic [WORDLENGTH-1:0] ref_wr_data,
    input  logic [WORDLENGTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [AW:0]           err_cnt,
    output logic                  first_err_valid,
    output logic [AW-1:0]         first_err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_nxt;
    logic [WORDLENGTH-1:0] gold_mem [DATA_NUM];
    logic [AW-1:0]         idx;
    logic [WW-1:0]         wdog;

    logic       acc, mismatch, last_acc, wd_expire;
    logic [AW:0] err_cnt_nxt;

    assign acc         = (state == RUN) && s_tvalid;
    assign mismatch    = acc && (s_tdata != gold_mem[idx]);
    assign last_acc    = acc && (idx == AW'(DATA_NUM - 1));
    assign wd_expire   = (state == RUN) && !s_tvalid && (wdog == WW'(TIMEOUT - 1));
    assign err_cnt_nxt = err_cnt + {{AW{1'b0}}, mismatch};

    // Golden table has no reset so a srst between runs keeps the reference data.
    always_ff @(posedge clk) begin
        if (!srst && ref_wr_en && state != RUN)
            gold_mem[ref_wr_addr] <= ref_wr_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_acc || wd_expire) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            idx             <= '0;
            wdog            <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            if (state != RUN && start) begin
                idx             <= '0;
                err_cnt         <= '0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
                timeout         <= 1'b0;
                wdog            <= '0;
                pass            <= 1'b0;
            end else if (acc) begin
                wdog    <= '0;
                err_cnt <= err_cnt_nxt;
                // idx parks on the last index so it never wraps within a run
                if (!last_acc)
                    idx <= idx + AW'(1);
                if (mismatch && !first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= idx;
                end
                if (last_acc)
                    pass <= (err_cnt_nxt == '0);
            end else if (state == RUN) begin
                if (wd_expire) begin
                    timeout <= 1'b1;
                    pass    <= 1'b0;
                end else begin
                    wdog <= wdog + WW'(1);
                end
            end
        end
    end

endmodule
